// File: rtl/dom_shared_gf4_inv_out.sv
// Masked (DOM) output stage of the shared GF(2^4) inverter: squares D
// share-wise and multiplies it with delayed A/B using DOM-indep products.
//
// Ports:
//   ClkxCI, RstxBI : clock, asynchronous active-low reset
//   ValidxSI       : A/B inputs valid this cycle
//   _AxDI, _BxDI   : hi/lo GF(2^2) halves, share i at [2i+1:2i]
//   _DxDI          : upstream D shares, UPSTREAM_LATENCY cycles after A/B
//   _ZxDI          : fresh randomness, lower half hi mult, upper half lo mult
//   ValidxSO       : _QxDO holds a new result
//   _QxDO          : share i at [4i+3:4i], {D^-1*B, D^-1*A}

module gf2_mul #(
   parameter int N = 2
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] q_o
);
   // GF(2^2) product in normal basis {W^2, W}
   logic t;
   assign t   = (a_i[1] ^ a_i[0]) & (b_i[1] ^ b_i[0]);
   assign q_o = {t ^ (a_i[1] & b_i[1]), t ^ (a_i[0] & b_i[0])};
endmodule

module dom_shared_gf4_inv_out #(
   parameter int SHARES           = 2,
   parameter int UPSTREAM_LATENCY = 1
) (
   input  logic                         ClkxCI,
   input  logic                         RstxBI,
   input  logic                         ValidxSI,
   input  logic [2*SHARES-1:0]          _AxDI,
   input  logic [2*SHARES-1:0]          _BxDI,
   input  logic [2*SHARES-1:0]          _DxDI,
   input  logic [2*SHARES*(SHARES-1)-1:0] _ZxDI,
   output logic                         ValidxSO,
   output logic [4*SHARES-1:0]          _QxDO
);
   localparam int W  = 2 * SHARES;
   localparam int L  = UPSTREAM_LATENCY;
   localparam int ZH = SHARES * (SHARES - 1);

   logic [W-1:0] a_dl, b_dl;
   logic         v_dl;

   generate
      if (L == 0) begin : g_wire
         assign a_dl = _AxDI;
         assign b_dl = _BxDI;
         assign v_dl = ValidxSI;
      end else begin : g_dly
         logic [L-1:0][W-1:0] a_q, b_q;
         logic [L-1:0]        v_q;

         always_ff @(posedge ClkxCI or negedge RstxBI) begin
            if (!RstxBI) begin
               a_q <= '0;
               b_q <= '0;
               v_q <= '0;
            end else begin
               v_q[0] <= ValidxSI;
               if (ValidxSI) begin
                  a_q[0] <= _AxDI;
                  b_q[0] <= _BxDI;
               end
               for (int k = 1; k < L; k++) begin
                  v_q[k] <= v_q[k-1];
                  if (v_q[k-1]) begin
                     a_q[k] <= a_q[k-1];
                     b_q[k] <= b_q[k-1];
                  end
               end
            end
         end

         assign a_dl = a_q[L-1];
         assign b_dl = b_q[L-1];
         assign v_dl = v_q[L-1];
      end
   endgenerate

   // inverse in GF(2^2) is squaring, a share-local bit swap
   logic [W-1:0] e;
   logic [SHARES-1:0][SHARES-1:0][1:0] hi_d, lo_d, hi_q, lo_q;
   logic vo_q;

   generate
      for (genvar i = 0; i < SHARES; i++) begin : g_sh
         assign e[2*i+1:2*i] = {_DxDI[2*i], _DxDI[2*i+1]};
      end

      for (genvar i = 0; i < SHARES; i++) begin : g_i
         for (genvar j = 0; j < SHARES; j++) begin : g_j
            logic [1:0] mh, ml;

            gf2_mul #(.N(2)) u_mh (
               .a_i (e[2*i+:2]),
               .b_i (b_dl[2*j+:2]),
               .q_o (mh)
            );

            gf2_mul #(.N(2)) u_ml (
               .a_i (e[2*i+:2]),
               .b_i (a_dl[2*j+:2]),
               .q_o (ml)
            );

            if (i == j) begin : g_inner
               assign hi_d[i][j] = mh;
               assign lo_d[i][j] = ml;
            end else begin : g_cross
               // (i,j) and (j,i) share one pair index
               localparam int LO = (i < j) ? i : j;
               localparam int HI = (i < j) ? j : i;
               localparam int P  = LO*SHARES - (LO*(LO+1))/2 + (HI-LO-1);
               assign hi_d[i][j] = mh ^ _ZxDI[2*P+:2];
               assign lo_d[i][j] = ml ^ _ZxDI[ZH+2*P+:2];
            end
         end
      end
   endgenerate

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         hi_q <= '0;
         lo_q <= '0;
         vo_q <= 1'b0;
      end else begin
         vo_q <= v_dl;
         if (v_dl) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
         end
      end
   end

   assign ValidxSO = vo_q;

   // share compression only ever sees registered terms
   always_comb begin
      logic [1:0] hs, ls;
      _QxDO = '0;
      hs    = '0;
      ls    = '0;
      for (int i = 0; i < SHARES; i++) begin
         hs = '0;
         ls = '0;
         for (int j = 0; j < SHARES; j++) begin
            hs = hs ^ hi_q[i][j];
            ls = ls ^ lo_q[i][j];
         end
         _QxDO[4*i+:4] = {hs, ls};
      end
   end
endmodule

// File: tb/tb_dom_shared_gf4_inv_out.sv
// Directed/random bench for dom_shared_gf4_inv_out.
// Runs SHARES=2/LAT=1 and SHARES=3/LAT=2 side by side.

module tb_dom_shared_gf4_inv_out;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        vin = 1'b0;
   logic [3:0]  a2 = '0, b2 = '0, d2 = '0, z2 = '0;
   logic [5:0]  a3 = '0, b3 = '0, d3 = '0;
   logic [11:0] z3 = '0;
   logic        v2o, v3o;
   logic [7:0]  q2;
   logic [11:0] q3;

   dom_shared_gf4_inv_out #(.SHARES(2), .UPSTREAM_LATENCY(1)) u_d2 (
      .ClkxCI(clk), .RstxBI(rst_n), .ValidxSI(vin),
      ._AxDI(a2), ._BxDI(b2), ._DxDI(d2), ._ZxDI(z2),
      .ValidxSO(v2o), ._QxDO(q2)
   );

   dom_shared_gf4_inv_out #(.SHARES(3), .UPSTREAM_LATENCY(2)) u_d3 (
      .ClkxCI(clk), .RstxBI(rst_n), .ValidxSI(vin),
      ._AxDI(a3), ._BxDI(b3), ._DxDI(d3), ._ZxDI(z3),
      .ValidxSO(v3o), ._QxDO(q3)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [11:0] obs,
                      input logic [11:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // golden GF(4) arithmetic via discrete log (W generates the group)
   function automatic logic [1:0] ex(int k);
      case (k % 3)
         0: return 2'b11;
         1: return 2'b01;
         default: return 2'b10;
      endcase
   endfunction

   function automatic int lg(logic [1:0] x);
      case (x)
         2'b01: return 1;
         2'b10: return 2;
         default: return 0;
      endcase
   endfunction

   function automatic logic [1:0] gmul(logic [1:0] x, logic [1:0] y);
      if (x == 2'b00 || y == 2'b00) return 2'b00;
      return ex(lg(x) + lg(y));
   endfunction

   function automatic logic [1:0] ginv(logic [1:0] x);
      if (x == 2'b00) return 2'b00;
      return ex(3 - lg(x));
   endfunction

   function automatic logic [3:0] gold(logic [1:0] a, logic [1:0] b,
                                       logic [1:0] d);
      logic [1:0] e;
      e = ginv(d);
      return {gmul(e, b), gmul(e, a)};
   endfunction

   function automatic logic [3:0] mask2(logic [1:0] v);
      logic [1:0] r;
      r = 2'($urandom);
      return {r, v ^ r};
   endfunction

   function automatic logic [5:0] mask3(logic [1:0] v);
      logic [1:0] r1, r2;
      r1 = 2'($urandom);
      r2 = 2'($urandom);
      return {r2, r1, v ^ r1 ^ r2};
   endfunction

   function automatic logic [3:0] rec2(logic [7:0] q);
      return q[3:0] ^ q[7:4];
   endfunction

   function automatic logic [3:0] rec3(logic [11:0] q);
      return q[3:0] ^ q[7:4] ^ q[11:8];
   endfunction

   localparam int N = 1010;
   logic       ov [N];
   logic [1:0] oa [N], ob [N], od [N];
   logic [3:0] h2 = '0, h3 = '0;

   initial begin
      for (int k = 0; k < N; k++) begin
         ov[k] = 1'b1;
         oa[k] = 2'($urandom);
         ob[k] = 2'($urandom);
         od[k] = 2'($urandom);
      end
      ov[0] = 1'b1; oa[0] = 2'b01; ob[0] = 2'b10; od[0] = 2'b11;
      ov[1] = 1'b0;
      ov[2] = 1'b1; oa[2] = 2'b11; ob[2] = 2'b11; od[2] = 2'b01;
      ov[3] = 1'b1; ov[4] = 1'b0; ov[5] = 1'b1; ov[6] = 1'b0;

      #23;
      chk("rst_v2", 12'(v2o), 12'h0);
      chk("rst_q2", 12'(q2), 12'h0);
      chk("rst_v3", 12'(v3o), 12'h0);
      chk("rst_q3", q3, 12'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < N + 4; n++) begin
         int k2, k3, kd2, kd3;
         @(negedge clk);
         k2 = n - 2;
         k3 = n - 3;
         if (k2 >= 0 && k2 < N && ov[k2]) begin
            h2 = gold(oa[k2], ob[k2], od[k2]);
            chk("v2", 12'(v2o), 12'h1);
            chk("q2", 12'(rec2(q2)), 12'(h2));
         end else begin
            chk("v2_idle", 12'(v2o), 12'h0);
            chk("q2_hold", 12'(rec2(q2)), 12'(h2));
         end
         if (k3 >= 0 && k3 < N && ov[k3]) begin
            h3 = gold(oa[k3], ob[k3], od[k3]);
            chk("v3", 12'(v3o), 12'h1);
            chk("q3", 12'(rec3(q3)), 12'(h3));
         end else begin
            chk("v3_idle", 12'(v3o), 12'h0);
            chk("q3_hold", 12'(rec3(q3)), 12'(h3));
         end
         if (n == 2) chk("vec1", 12'(rec2(q2)), 12'h9);
         if (n == 4) chk("vec2_inv_w", 12'(rec2(q2)), 12'hA);

         if (n < N) begin
            vin = ov[n];
            a2 = (n == 0) ? {2'b00, oa[n]} : mask2(oa[n]);
            b2 = (n == 0) ? {2'b00, ob[n]} : mask2(ob[n]);
            a3 = mask3(oa[n]);
            b3 = mask3(ob[n]);
         end else begin
            vin = 1'b0;
            a2 = 4'($urandom);
            b2 = 4'($urandom);
            a3 = 6'($urandom);
            b3 = 6'($urandom);
         end
         kd2 = n - 1;
         kd3 = n - 2;
         if (kd2 >= 0 && kd2 < N)
            d2 = (kd2 == 0) ? {2'b00, od[0]} : mask2(od[kd2]);
         else
            d2 = 4'($urandom);
         if (kd3 >= 0 && kd3 < N)
            d3 = mask3(od[kd3]);
         else
            d3 = 6'($urandom);
         z2 = (n == 1) ? 4'h0 : 4'($urandom);
         z3 = 12'($urandom);
      end

      // two operations in flight, then an asynchronous reset
      vin = 1'b1;
      a2 = 4'($urandom); b2 = 4'($urandom);
      a3 = 6'($urandom); b3 = 6'($urandom);
      @(negedge clk);
      d2 = 4'($urandom); d3 = 6'($urandom);
      a2 = 4'($urandom); a3 = 6'($urandom);
      @(negedge clk);
      vin = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_v2", 12'(v2o), 12'h0);
      chk("mid_rst_q2", 12'(q2), 12'h0);
      chk("mid_rst_v3", 12'(v3o), 12'h0);
      chk("mid_rst_q3", q3, 12'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_v2", 12'(v2o), 12'h0);
         chk("post_rst_v3", 12'(v3o), 12'h0);
         chk("post_rst_q2", 12'(q2), 12'h0);
      end

      vin = 1'b1;
      a2 = mask2(2'b10); b2 = mask2(2'b01);
      a3 = mask3(2'b10); b3 = mask3(2'b01);
      @(negedge clk);
      vin = 1'b0;
      d2 = mask2(2'b10);
      z2 = 4'($urandom);
      @(negedge clk);
      d3 = mask3(2'b10);
      z3 = 12'($urandom);
      chk("new_v2", 12'(v2o), 12'h1);
      chk("new_q2", 12'(rec2(q2)), 12'hB);
      @(negedge clk);
      chk("new_v3", 12'(v3o), 12'h1);
      chk("new_q3", 12'(rec3(q3)), 12'hB);
      chk("new_v2_gap", 12'(v2o), 12'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
